// File: rtl/crc16_checker.sv
// ---------------------------------------------------------------------------
// crc16_checker
//
// Receives one 50-bit frame {data[33:0], crc[15:0]} and recomputes CRC-16
// over the payload. The CRC is MSB-first and non-reflected, with no final
// XOR, and starts from INIT. The payload is zero-extended to 40 bits and
// folded in as 5 bytes, one byte per cycle, most significant byte first.
// It then reports whether the received CRC matched.
//
// Handshake: a frame is taken on a rising edge where frame_valid and
// frame_ready are both high. frame_ready is a pure decode of the state
// register, so it is high only in IDLE. frame_valid is ignored while a
// frame is in flight; nothing is queued. After acceptance frame_in may
// change freely. result_valid is a one-cycle strobe in the 6th cycle after
// the accepting edge. Throughput is one frame every 7 cycles.
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous, active-high
//   frame_in     {data[33:0], crc[15:0]}
//   frame_valid  frame_in holds a frame to check
//   frame_ready  block can accept a frame this cycle
//   data_out     payload of the last checked frame (held)
//   result_valid one-cycle strobe: data_out/crc_ok/crc_err are fresh
//   crc_ok       recomputed CRC equals received CRC (held)
//   crc_err      recomputed CRC differs from received CRC (held)
//   err_count    saturating count of failed frames since reset
// ---------------------------------------------------------------------------
module crc16_checker #(
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [49:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [33:0] data_out,
    output logic        result_valid,
    output logic        crc_ok,
    output logic        crc_err,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  byte_idx;
    logic [15:0] crc_reg;
    logic [33:0] cap_data;
    logic [15:0] cap_crc;

    logic [39:0] payload;
    logic [7:0]  cur_byte;
    logic [15:0] crc_next;
    logic        crc_match;

    // Eight serial shift-register steps, unrolled into one combinational byte update.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ POLY;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign payload = {6'b0, cap_data};

    always_comb begin
        cur_byte = payload[7:0];
        case (byte_idx)
            3'd0:    cur_byte = payload[39:32];
            3'd1:    cur_byte = payload[31:24];
            3'd2:    cur_byte = payload[23:16];
            3'd3:    cur_byte = payload[15:8];
            default: cur_byte = payload[7:0];
        endcase
    end

    assign crc_next  = crc_byte(crc_reg, cur_byte);
    // This compares against the value crc_reg takes on entering DONE.
    // That lets the result flops load on the same edge as the state change.
    assign crc_match = (crc_next == cap_crc);

    assign frame_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_idx     <= 3'd0;
            crc_reg      <= INIT;
            cap_data     <= 34'd0;
            cap_crc      <= 16'd0;
            data_out     <= 34'd0;
            result_valid <= 1'b0;
            crc_ok       <= 1'b0;
            crc_err      <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        cap_data <= frame_in[49:16];
                        cap_crc  <= frame_in[15:0];
                        crc_reg  <= INIT;
                        byte_idx <= 3'd0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    crc_reg  <= crc_next;
                    byte_idx <= byte_idx + 3'd1;
                    if (byte_idx == 3'd4) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        data_out     <= cap_data;
                        crc_ok       <= crc_match;
                        crc_err      <= !crc_match;
                        if (!crc_match && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/crc16_checker.md
CRC16_CHECKER -- requirements
Module: crc16_checker

Interface
REQ-001 SHALL have ports: clk  input  1  single system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: frame_in  input  50  received frame, {data[33:0], crc[15:0]}.
REQ-004 SHALL have ports: frame_valid  input  1  frame_in holds a frame to be checked.
REQ-005 SHALL have ports: frame_ready  output  1  block can accept a frame this cycle.
REQ-006 SHALL have ports: data_out  output  34  payload of the last checked frame.
REQ-007 SHALL have ports: result_valid  output  1  one-cycle strobe; crc_ok/crc_err/data_out valid.
REQ-008 SHALL have ports: crc_ok  output  1  recomputed CRC equals received CRC.
REQ-009 SHALL have ports: crc_err  output  1  recomputed CRC differs from received CRC.
REQ-010 SHALL have ports: err_count  output  8  saturating count of failed frames since reset.
REQ-011 SHALL have parameter: POLY, 16'h1021, CRC-16 generator polynomial.
REQ-012 SHALL have parameter: INIT, 16'h0000, CRC register start value.

Function
REQ-013 CRC SHALL be the same CRC-16 the team's transmit side uses: MSB-first, non-reflected, no final XOR, start value INIT.
REQ-014 Payload SHALL be zero-extended to 40 bits ({6'b0, data[33:0]}) and processed as 5 bytes, bits [39:32] first, [7:0] last.
REQ-015 FSM states SHALL be IDLE, CALC, DONE.
REQ-016 IDLE: frame_ready=1; on frame_valid=1, capture frame_in, load crc register with INIT, byte index 0, go to CALC.
REQ-017 Acceptance SHALL happen only when frame_valid and frame_ready are both high on the same edge; frame_in may change freely afterwards.
REQ-018 CALC: frame_ready=0; each cycle SHALL fold one byte into the crc register (8 serial polynomial steps unrolled combinationally), increment index; after index 4 go to DONE.
REQ-019 DONE: result_valid=1 for exactly one cycle; crc_ok=(crc_reg==captured crc); crc_err=!crc_ok; data_out=captured payload; go to IDLE.
REQ-020 Latency SHALL be fixed: result_valid high in the 6th cycle after the accepting edge; throughput one frame per 7 cycles.
REQ-021 frame_ready SHALL be 0 in CALC and DONE; frame_valid in those states SHALL be ignored (not queued).
REQ-022 crc_ok, crc_err, data_out SHALL hold their last values until the next DONE; crc_ok and crc_err SHALL never both be 1.
REQ-023 err_count SHALL increment by 1 in DONE when crc_err=1; at 8'hFF it SHALL stay 8'hFF.
REQ-024 No combinational path from frame_valid to frame_ready; frame_ready is a decode of the state register.

Reset
REQ-025 reset=1 SHALL on the next edge force state IDLE, frame_ready=1, result_valid=0, crc_ok=0, crc_err=0, data_out=0, err_count=0, crc register=INIT.
REQ-026 reset asserted mid-CALC or in DONE SHALL abort the frame with no result_valid strobe and no err_count change.
REQ-027 reset SHALL take priority over frame_valid on the same edge; no frame accepted that cycle.

Verification
REQ-028 frame_in=50'h0, valid 1 cycle -> result_valid exactly 6 cycles later, crc_ok=1, crc_err=0, data_out=0, err_count=0.
REQ-029 frame_in={34'h0,16'h0001} -> crc_ok=0, crc_err=1, err_count=1.
REQ-030 Golden frame from a 0x1021 reference model for random payloads, then each of the 50 single-bit flips -> golden gives crc_ok=1; every flip gives crc_err=1.
REQ-031 frame_valid held high continuously with back-to-back frames -> one acceptance per 7 cycles, frame_ready low in CALC/DONE, no frame dropped or double-counted.
REQ-032 reset pulsed at CALC cycle 3 -> no result_valid, outputs at reset values, next frame checked correctly.
REQ-033 300 corrupted frames -> err_count saturates at 8'hFF and stays there.
